core_axi_lite_master: RTL
=========================

// Module: core_axi_lite_master
// PURPOSE
//  AXI-lite master: the initiator end of the memory AXI-lite link. Converts a simple
//  core-side request (addr/wdata/wmask + wen/ren, held until done) into one AXI-lite
//  write (AW+W+B) or read (AR+R) transaction. Returns read data plus a one-cycle
//  completion pulse. Sits between the pipeline's memory stage and the AXI_ift bus.
// PARAMETERS
//  C_M_AXI_DATA_WIDTH  64  data bus width; wstrb/wmask width = C_M_AXI_DATA_WIDTH/8
//  C_M_AXI_ADDR_WIDTH  64  address bus width
// PORTS
//  master_ift.clk   in   1      clock, from AXI_ift; all logic on posedge
//  master_ift.rstn  in   1      reset, asynchronous, active-low, from AXI_ift
//  master_ift       io   AXI_ift.Master  drives Mw.{awaddr,awvalid,wdata,wstrb,wvalid,bready},
//                                Mr.{araddr,arvalid,rready}; samples Sw.*/Sr.*
//  addr_core        in   ADDR   request address
//  wdata_core       in   DATA   write data
//  wmask_core       in   DATA/8 byte strobes for write
//  wen_core         in   1      write request; held with operands until valid_core
//  ren_core         in   1      read request; held with addr until valid_core
//  rdata_core       out  DATA   registered read data, valid with valid_core, held after
//  valid_core       out  1      1-cycle pulse: transaction complete
//  err_core         out  1      1-cycle pulse with valid_core when bresp/rresp != 2'b00
//  debug_axi_wstate out  2      write FSM state
//  debug_axi_rstate out  2      read FSM state
// BEHAVIOUR
//  Reset (rstn=0, immediate): both FSMs IDLE; awvalid,wvalid,bready,arvalid,rready,
//   valid_core,err_core=0; awaddr,wdata,wstrb,araddr,rdata_core=0. Reset mid-transaction
//   abandons it; no valid_core pulse is produced for it.
//  All AXI outputs and core outputs are registered.
//  Write FSM (2b): WIDLE=00, WADDR=01, WRESP=10, WDONE=11.
//   WIDLE: wen_core=1 -> latch addr/wdata/wmask into awaddr/wdata/wstrb; awvalid=wvalid=1; ->WADDR.
//   WADDR: drop awvalid on the edge awready is sampled 1, and wvalid on the edge wready
//    is sampled 1; the two are tracked independently (either order, or same cycle).
//    Once both are accepted: bready=1 ->WRESP.
//   WRESP: bvalid=1 -> bready=0, valid_core=1, err_core=(bresp!=0) ->WDONE.
//   WDONE: valid_core/err_core=0 ->WIDLE.
//  Read FSM (2b): RIDLE=00, RADDR=01, RDATA=10, RDONE=11.
//   RIDLE: ren_core=1 & wen_core=0 & write FSM in WIDLE -> araddr<=addr_core,
//    arvalid=1 ->RADDR.
//   RADDR: arready=1 -> arvalid=0, rready=1 ->RDATA.
//   RDATA: rvalid=1 -> rready=0, rdata_core<=rdata, valid_core=1,
//    err_core=(rresp!=0) ->RDONE.
//   RDONE: pulses cleared ->RIDLE.
//  One outstanding transaction total; the write FSM and read FSM are never both non-IDLE.
//  wen_core & ren_core both 1: write wins; no AR is issued for that request.
//  Core contract: drop or replace the request on the edge valid_core=1 is sampled.
//   IDLE re-samples one cycle after DONE, so a held request is re-issued (intended for
//   back-to-back).
//  Valid signals never depend combinationally on ready inputs. valid, once asserted,
//   holds until its handshake completes, with payload stable.
//  Min latency, zero-wait slave: request seen cycle 0 -> a/w valid cycle 1 -> resp valid
//   cycle 2 -> valid_core cycle 3 (same for reads).
//  Unbounded waits are allowed: no timeout, and the FSM stalls while ready/bvalid/rvalid=0.
// TESTING
//  1 write 0x80 data 0x1122334455667788 mask 0xFF, zero-wait slave -> AW/W handshake cyc1,
//    B cyc2, valid_core=1 cyc3 only, err_core=0
//  2 write with awready 2 cycles before wready (and reversed) -> each valid drops at its own
//    handshake; exactly one B; one valid_core
//  3 read 0x100, slave rdata 0xDEADBEEFCAFEF00D after 3 wait cycles -> arvalid held stable
//    with addr; rdata_core=0xDEADBEEFCAFEF00D with valid_core; data held after
//  4 wen=ren=1 -> only AW/W issued, arvalid stays 0; bresp=2'b10 -> err_core pulses with
//    valid_core
//  5 rstn=0 while in RDATA and in WADDR -> all valids/readys 0 same cycle, FSMs IDLE, no pulse
//  6 back-to-back write then read against MemAxi_lite-style slave -> two valid_core pulses,
//    read returns the written data

Source files
------------

// File: rtl/core_axi_lite_master.sv
// core_axi_lite_master
// Initiator end of the memory AXI-lite link. A core-side request is turned into
// exactly one AXI-lite write (AW+W+B) or one read (AR+R). The core holds the
// request until valid_core pulses.
//
// Ports
//   clk, rstn              clock (posedge) and asynchronous active-low reset
//   addr_core              request address
//   wdata_core/wmask_core  write data and byte strobes
//   wen_core/ren_core      write / read request, held until valid_core
//   rdata_core             registered read data, valid with valid_core, held after
//   valid_core             one-cycle completion pulse
//   err_core               one-cycle pulse with valid_core on a non-OKAY response
//   debug_axi_wstate/rstate  write / read FSM state
//   aw*/w*/b*/ar*/r*       AXI-lite master channels; all master outputs registered
module core_axi_lite_master #(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64
) (
    input  logic                            clk,
    input  logic                            rstn,

    // core side
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_core,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_core,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] wmask_core,
    input  logic                            wen_core,
    input  logic                            ren_core,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_core,
    output logic                            valid_core,
    output logic                            err_core,
    output logic [1:0]                      debug_axi_wstate,
    output logic [1:0]                      debug_axi_rstate,

    // AXI-lite write address channel
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr,
    output logic                            awvalid,
    input  logic                            awready,

    // AXI-lite write data channel
    output logic [C_M_AXI_DATA_WIDTH-1:0]   wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb,
    output logic                            wvalid,
    input  logic                            wready,

    // AXI-lite write response channel
    input  logic [1:0]                      bresp,
    input  logic                            bvalid,
    output logic                            bready,

    // AXI-lite read address channel
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr,
    output logic                            arvalid,
    input  logic                            arready,

    // AXI-lite read data channel
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]                      rresp,
    input  logic                            rvalid,
    output logic                            rready
);

    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] W_IDLE = 2'b00;
    localparam logic [1:0] W_ADDR = 2'b01;
    localparam logic [1:0] W_RESP = 2'b10;
    localparam logic [1:0] W_DONE = 2'b11;

    localparam logic [1:0] R_IDLE = 2'b00;
    localparam logic [1:0] R_ADDR = 2'b01;
    localparam logic [1:0] R_DATA = 2'b10;
    localparam logic [1:0] R_DONE = 2'b11;

    logic [1:0]    w_state, w_state_d;
    logic [1:0]    r_state, r_state_d;

    logic [AW-1:0] awaddr_d;
    logic          awvalid_d;
    logic [DW-1:0] wdata_d;
    logic [SW-1:0] wstrb_d;
    logic          wvalid_d;
    logic          bready_d;
    logic [AW-1:0] araddr_d;
    logic          arvalid_d;
    logic          rready_d;
    logic [DW-1:0] rdata_core_d;
    logic          valid_core_d;
    logic          err_core_d;

    // A channel counts as accepted once its valid is low in W_ADDR, or its
    // handshake completes on this edge.
    logic          aw_ok;
    logic          w_ok;

    assign aw_ok = !awvalid || awready;
    assign w_ok  = !wvalid  || wready;

    assign debug_axi_wstate = w_state;
    assign debug_axi_rstate = r_state;

    // Next-state and next-output logic for both FSMs
    always_comb begin
        w_state_d    = w_state;
        r_state_d    = r_state;
        awaddr_d     = awaddr;
        awvalid_d    = awvalid;
        wdata_d      = wdata;
        wstrb_d      = wstrb;
        wvalid_d     = wvalid;
        bready_d     = bready;
        araddr_d     = araddr;
        arvalid_d    = arvalid;
        rready_d     = rready;
        rdata_core_d = rdata_core;
        valid_core_d = 1'b0;
        err_core_d   = 1'b0;

        // Write FSM; only starts when the read side is idle
        case (w_state)
            W_IDLE: begin
                if (wen_core && (r_state == R_IDLE)) begin
                    awaddr_d  = addr_core;
                    wdata_d   = wdata_core;
                    wstrb_d   = wmask_core;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    w_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                if (awready) begin
                    awvalid_d = 1'b0;
                end
                if (wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_ok && w_ok) begin
                    bready_d  = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bvalid) begin
                    bready_d     = 1'b0;
                    valid_core_d = 1'b1;
                    err_core_d   = (bresp != 2'b00);
                    w_state_d    = W_DONE;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase

        // Read FSM; a concurrent write request takes priority
        case (r_state)
            R_IDLE: begin
                if (ren_core && !wen_core && (w_state == W_IDLE)) begin
                    araddr_d  = addr_core;
                    arvalid_d = 1'b1;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid) begin
                    rready_d     = 1'b0;
                    rdata_core_d = rdata;
                    valid_core_d = 1'b1;
                    err_core_d   = (rresp != 2'b00);
                    r_state_d    = R_DONE;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state    <= W_IDLE;
            r_state    <= R_IDLE;
            awaddr     <= AW'(0);
            awvalid    <= 1'b0;
            wdata      <= DW'(0);
            wstrb      <= SW'(0);
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            araddr     <= AW'(0);
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            rdata_core <= DW'(0);
            valid_core <= 1'b0;
            err_core   <= 1'b0;
        end else begin
            w_state    <= w_state_d;
            r_state    <= r_state_d;
            awaddr     <= awaddr_d;
            awvalid    <= awvalid_d;
            wdata      <= wdata_d;
            wstrb      <= wstrb_d;
            wvalid     <= wvalid_d;
            bready     <= bready_d;
            araddr     <= araddr_d;
            arvalid    <= arvalid_d;
            rready     <= rready_d;
            rdata_core <= rdata_core_d;
            valid_core <= valid_core_d;
            err_core   <= err_core_d;
        end
    end

endmodule
